// File: rtl/uart_rx_oversampler.sv
// Oversampling edge/bit counters and 3-sample majority voter feeding the UART RX FSM.
// Define UART_RX_SYNC_EN to pass i_rx_in through a 2-flop synchronizer before sampling.
module uart_rx_oversampler #(
  parameter int EDGE_W = 5,
  parameter int BIT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_in,
  input  logic [5:0]        i_Prescale,
  input  logic              i_enable_cnt,
  input  logic              i_data_samp_en,
  output logic [EDGE_W-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]  o_bit_cnt,
  output logic              o_sampled_bit,
  output logic              o_sample_valid
);

  logic       r_rx;
  logic [5:0] p_eff;
  logic [6:0] edge_ext;
  logic [6:0] last_edge;
  logic [6:0] mid;
  logic       s0, s1, s2;
  logic       vote;

`ifdef UART_RX_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_rx_in;
      sync2 <= sync1;
    end
  end

  assign r_rx = sync2;
`else
  assign r_rx = i_rx_in;
`endif

  // Out-of-range prescale falls back to 8 so the counter can never run past its width.
  assign p_eff     = (i_Prescale >= 6'd8 && i_Prescale <= 6'd32) ? i_Prescale : 6'd8;
  assign edge_ext  = 7'(o_edge_cnt);
  assign last_edge = {1'b0, p_eff} - 7'd1;
  assign mid       = {2'b00, p_eff[5:1]};
  assign vote      = (s0 & s1) | (s0 & s2) | (s1 & s2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_edge_cnt <= '0;
      o_bit_cnt  <= '0;
    end else if (!i_enable_cnt) begin
      o_edge_cnt <= '0;
      o_bit_cnt  <= '0;
    end else if (edge_ext == last_edge) begin
      o_edge_cnt <= '0;
      o_bit_cnt  <= o_bit_cnt + 1'b1;
    end else begin
      o_edge_cnt <= o_edge_cnt + 1'b1;
    end
  end

  // mid >= 4 for every legal P, so mid-1 never underflows.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s0             <= 1'b1;
      s1             <= 1'b1;
      s2             <= 1'b1;
      o_sampled_bit  <= 1'b1;
      o_sample_valid <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      if (i_data_samp_en) begin
        if (edge_ext == mid - 7'd1) s0 <= r_rx;
        if (edge_ext == mid)        s1 <= r_rx;
        if (edge_ext == mid + 7'd1) s2 <= r_rx;
        if (edge_ext == mid + 7'd2) begin
          o_sampled_bit  <= vote;
          o_sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler (default build, no input synchronizer).
module tb_uart_rx_oversampler;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx_in;
  logic [5:0] i_Prescale;
  logic       i_enable_cnt;
  logic       i_data_samp_en;
  logic [4:0] o_edge_cnt;
  logic [3:0] o_bit_cnt;
  logic       o_sampled_bit;
  logic       o_sample_valid;

  int total = 0;
  int bad   = 0;

  uart_rx_oversampler #(.EDGE_W(5), .BIT_W(4)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rx_in        (i_rx_in),
    .i_Prescale     (i_Prescale),
    .i_enable_cnt   (i_enable_cnt),
    .i_data_samp_en (i_data_samp_en),
    .o_edge_cnt     (o_edge_cnt),
    .o_bit_cnt      (o_bit_cnt),
    .o_sampled_bit  (o_sampled_bit),
    .o_sample_valid (o_sample_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_edge;
    int exp_bit;
    logic exp_samp;

    i_reset        = 1'b0;
    i_rx_in        = 1'b1;
    i_Prescale     = 6'd8;
    i_enable_cnt   = 1'b1;
    i_data_samp_en = 1'b0;

    // 1: reset with enable high
    tick();
    i_reset = 1'b1;
    tick();
    check("rst_edge", o_edge_cnt, 0);
    check("rst_bit", o_bit_cnt, 0);
    check("rst_sampled", o_sampled_bit, 1);
    check("rst_valid", o_sample_valid, 0);
    i_reset = 1'b0;

    // 2: P=8 counting for 88 cycles
    exp_edge = 0;
    exp_bit  = 0;
    for (int i = 0; i < 88; i++) begin
      tick();
      if (exp_edge == 7) begin
        exp_edge = 0;
        exp_bit  = (exp_bit + 1) % 16;
      end else begin
        exp_edge++;
      end
      check("p8_edge", o_edge_cnt, exp_edge);
      check("p8_bit", o_bit_cnt, exp_bit);
    end
    check("p8_bit_final", o_bit_cnt, 11);

    // 4: illegal prescales fall back to 8
    i_enable_cnt = 1'b0;
    tick();
    check("dis_edge", o_edge_cnt, 0);
    check("dis_bit", o_bit_cnt, 0);
    i_Prescale   = 6'd5;
    i_enable_cnt = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("p5_edge7", o_edge_cnt, 7);
    tick();
    check("p5_wrap_edge", o_edge_cnt, 0);
    check("p5_wrap_bit", o_bit_cnt, 1);
    i_enable_cnt = 1'b0;
    tick();
    i_Prescale   = 6'd40;
    i_enable_cnt = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("p40_edge7", o_edge_cnt, 7);
    tick();
    check("p40_wrap_edge", o_edge_cnt, 0);
    check("p40_wrap_bit", o_bit_cnt, 1);

    // 3: P=16 majority with a glitch at edge 8; samples 7,8,9, vote at 10
    i_enable_cnt = 1'b0;
    tick();
    i_Prescale     = 6'd16;
    i_enable_cnt   = 1'b1;
    i_data_samp_en = 1'b1;
    exp_edge = 0;
    exp_bit  = 0;
    exp_samp = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_rx_in = (exp_edge == 8 && exp_bit == 0) ? 1'b1 : 1'b0;
      tick();
      if (exp_edge == 15) begin
        exp_edge = 0;
        exp_bit++;
      end else begin
        exp_edge++;
      end
      if (exp_edge == 11) exp_samp = 1'b0;
      check("p16_edge", o_edge_cnt, exp_edge);
      check("p16_valid", o_sample_valid, (exp_edge == 11) ? 1 : 0);
      check("p16_sampled", o_sampled_bit, exp_samp);
    end
    check("p16_bit", o_bit_cnt, 2);

    // 5: run to edge 5 of bit 3, then drop enable
    i_rx_in = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    check("pre_dis_edge", o_edge_cnt, 5);
    check("pre_dis_bit", o_bit_cnt, 3);
    i_enable_cnt = 1'b0;
    tick();
    check("mid_dis_edge", o_edge_cnt, 0);
    check("mid_dis_bit", o_bit_cnt, 0);
    check("mid_dis_sampled", o_sampled_bit, 0);
    check("mid_dis_valid", o_sample_valid, 0);

    // 6: recover sampled=1, then a full bit of rx=0 with sampling disabled
    i_rx_in      = 1'b1;
    i_enable_cnt = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("rx1_sampled", o_sampled_bit, 1);
    check("rx1_edge", o_edge_cnt, 0);
    i_rx_in        = 1'b0;
    i_data_samp_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("nosamp_valid", o_sample_valid, 0);
      check("nosamp_sampled", o_sampled_bit, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
